// File: rtl/connect4_pkg.sv
// Shared constants, winner codes, line table and FSM states
// for the 4x4 connect-four win checker.
package connect4_pkg;

    localparam int N        = 4;
    localparam int LINE_CNT = 10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Scan order: rows bottom-up, columns left-right, diagonal, anti-diagonal
    localparam logic [15:0] LINE_MASK [0:LINE_CNT-1] = '{
        16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
        16'h1111, 16'h2222, 16'h4444, 16'h8888,
        16'h8421, 16'h1248
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/connect4_win_checker_if.sv
// Board-in / result-out bundle between the column selector,
// the win checker and the game FSM / display.
interface connect4_win_checker_if;

    logic [15:0] gameboard;
    logic [15:0] players_cells;
    logic        start;
    logic        busy;
    logic        done;
    logic [1:0]  winner;
    logic        draw;
    logic [15:0] win_mask;
    logic        game_over;

    modport master (
        output gameboard, players_cells, start,
        input  busy, done, winner, draw, win_mask, game_over
    );

    modport slave (
        input  gameboard, players_cells, start,
        output busy, done, winner, draw, win_mask, game_over
    );

endinterface

// File: rtl/connect4_line_rom.sv
// Maps a scan index to the 16-bit cell mask of that line;
// indices past the last line give an empty mask.
module connect4_line_rom
    import connect4_pkg::*;
(
    input  logic [3:0]  i_idx,
    output logic [15:0] o_mask
);

    // Table lookup with out-of-range guard
    always_comb begin
        o_mask = '0;
        if (i_idx < 4'(LINE_CNT)) begin
            o_mask = LINE_MASK[i_idx];
        end
    end

endmodule

// File: rtl/connect4_win_checker.sv
// Sequential four-in-a-row scanner: one line per clock, early exit
// on the first win, sticky game_over until reset.
module connect4_win_checker
    import connect4_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    connect4_win_checker_if.slave  bus
);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_idx;
    logic [15:0] r_board;
    logic [15:0] r_owner;
    logic [1:0]  r_winner;
    logic        r_draw;
    logic [15:0] r_win_mask;
    logic        r_game_over;

    logic [15:0] w_mask;
    logic [15:0] w_own;
    logic        w_full;
    logic        w_p1;
    logic        w_p2;
    logic        w_hit;
    logic        w_last;
    logic        w_accept;

    connect4_line_rom u_rom (
        .i_idx  (r_idx),
        .o_mask (w_mask)
    );

    assign w_own  = r_owner & w_mask;
    assign w_full = (w_mask != 16'h0) && ((r_board & w_mask) == w_mask);
    assign w_p1   = w_full && (w_own == 16'h0);
    assign w_p2   = w_full && (w_own == w_mask);
    assign w_hit  = w_p1 || w_p2;
    assign w_last = (r_idx == 4'(LINE_CNT - 1));

    assign w_accept = (r_state == ST_IDLE) && bus.start && !r_game_over;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: scan until a win or the last line, then report once
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_hit || w_last) begin
                    w_next_state = ST_REPORT;
                end
            end
            ST_REPORT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Board latch, line index and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_board     <= '0;
            r_owner     <= '0;
            r_winner    <= WIN_NONE;
            r_draw      <= 1'b0;
            r_win_mask  <= '0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_board <= bus.gameboard;
                        r_owner <= bus.players_cells;
                        r_idx   <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        r_winner   <= w_p1 ? WIN_P1 : WIN_P2;
                        r_win_mask <= w_mask;
                        r_draw     <= 1'b0;
                    end else if (w_last) begin
                        r_winner   <= WIN_NONE;
                        r_win_mask <= '0;
                        r_draw     <= &r_board;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_REPORT: begin
                    r_game_over <= r_game_over
                                 | (r_winner != WIN_NONE)
                                 | r_draw;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_REPORT);
    assign bus.winner    = r_winner;
    assign bus.draw      = r_draw;
    assign bus.win_mask  = r_win_mask;
    assign bus.game_over = r_game_over;

endmodule

// File: tb/tb_connect4_win_checker.sv
// Directed and randomized checks of the connect-four win checker
// against a coordinate-based reference model.
module tb_connect4_win_checker;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    connect4_win_checker_if bus ();

    connect4_win_checker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk each line as a list of (row, col) cells
    function automatic void model(input logic [15:0] gb,
                                  input logic [15:0] pc,
                                  output logic [1:0] w,
                                  output logic [15:0] m,
                                  output logic d,
                                  output int lat);
        w   = 2'b00;
        m   = 16'h0;
        d   = (gb == 16'hFFFF);
        lat = 10;
        for (int l = 0; l < 10; l++) begin
            int occ;
            int p2;
            logic [15:0] lm;
            occ = 0;
            p2  = 0;
            lm  = 16'h0;
            for (int j = 0; j < 4; j++) begin
                int r;
                int c;
                if (l < 4) begin
                    r = l; c = j;
                end else if (l < 8) begin
                    r = j; c = l - 4;
                end else if (l == 8) begin
                    r = j; c = j;
                end else begin
                    r = j; c = 3 - j;
                end
                lm[r*4+c] = 1'b1;
                occ += int'(gb[r*4+c]);
                p2  += int'(pc[r*4+c]);
            end
            if (occ == 4 && (p2 == 0 || p2 == 4)) begin
                w   = (p2 == 0) ? 2'b01 : 2'b10;
                m   = lm;
                d   = 1'b0;
                lat = l + 1;
                return;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start before edge 0, scramble inputs afterwards,
    // return the edge number after which done was seen (-1 on timeout)
    task automatic run_scan(input logic [15:0] gb, input logic [15:0] pc,
                            output int lat);
        @(negedge clk);
        bus.gameboard     = gb;
        bus.players_cells = pc;
        bus.start         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start         = 1'b0;
        bus.gameboard     = 16'($urandom);
        bus.players_cells = 16'($urandom);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic game(input string tag, input logic [15:0] gb,
                        input logic [15:0] pc);
        logic [1:0]  ew;
        logic [15:0] em;
        logic        ed;
        int          el;
        int          lat;
        model(gb, pc, ew, em, ed, el);
        do_reset();
        run_scan(gb, pc, lat);
        chk({tag, "_latency"}, 32'(lat), 32'(el));
        chk({tag, "_winner"}, 32'(bus.winner), 32'(ew));
        chk({tag, "_mask"}, 32'(bus.win_mask), 32'(em));
        chk({tag, "_draw"}, 32'(bus.draw), 32'(ed));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.done), 32'(0));
        chk({tag, "_busy_clr"}, 32'(bus.busy), 32'(0));
        chk({tag, "_game_over"}, 32'(bus.game_over),
            32'((ew != 2'b00) || ed));
    endtask

    initial begin
        int dones;
        int busys;
        int lat;
        logic [1:0] rw;
        logic rd;
        logic [15:0] gb;
        logic [15:0] pc;

        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        bus.start         = 1'b0;
        bus.gameboard     = 16'h0;
        bus.players_cells = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs",
            {8'h0, bus.busy, bus.done, bus.winner, bus.draw,
             bus.game_over, bus.win_mask},
            32'h0);
        reset = 1'b0;

        game("row0_p1", 16'h000F, 16'h0000);
        game("col2_p2", 16'h4444, 16'h4444);
        game("anti_p1", 16'h1248, 16'h0000);
        game("mixed_row", 16'h000F, 16'h0008);
        game("full_draw", 16'hFFFF, 16'hC3C3);

        // game_over is set: a new start must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        busys = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busys++;
        end
        chk("over_ignore_done", 32'(dones), 32'(0));
        chk("over_ignore_busy", 32'(busys), 32'(0));
        chk("over_sticky", 32'(bus.game_over), 32'(1));

        // start again mid-scan must not restart or add a done
        do_reset();
        @(negedge clk);
        bus.gameboard     = 16'h0007;
        bus.players_cells = 16'h0000;
        bus.start         = 1'b1;
        @(posedge clk);
        dones = 0;
        lat   = -1;
        rw    = 2'b11;
        rd    = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.start = (k == 3) ? 1'b1 : 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                lat = k - 1;
                rw  = bus.winner;
                rd  = bus.draw;
            end
            @(posedge clk);
        end
        bus.start = 1'b0;
        chk("restart_dones", 32'(dones), 32'(1));
        chk("restart_latency", 32'(lat), 32'(10));
        chk("restart_winner", 32'(rw), 32'(0));
        chk("restart_draw", 32'(rd), 32'(0));

        // reset at edge 5 aborts a scan heading for line 8
        do_reset();
        @(negedge clk);
        bus.gameboard     = 16'h8421;
        bus.players_cells = 16'h0000;
        bus.start         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_busy_before", 32'(bus.busy), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_outputs",
            {8'h0, bus.busy, bus.done, bus.winner, bus.draw,
             bus.game_over, bus.win_mask},
            32'h0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'(0));

        // randomized boards, biased toward fuller boards
        for (int i = 0; i < 40; i++) begin
            gb = 16'($urandom) | 16'($urandom);
            if (i % 8 == 0) gb = 16'hFFFF;
            pc = 16'($urandom);
            game("rand", gb, pc);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
